// File: rtl/exmem_pkg.sv
// exmem_pkg: shared types for the execute-to-memory register.
// Branch funct3 codes, ALU status bit indices, queued entry layout.
package exmem_pkg;

  localparam int EX_XLEN   = 32;
  localparam int EX_REG_AW = 5;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam int ST_EQ  = 0;
  localparam int ST_LT  = 1;
  localparam int ST_LTU = 2;

  typedef struct packed {
    logic [EX_XLEN-1:0]   result;
    logic [EX_REG_AW-1:0] rd;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic [EX_XLEN-1:0]   store_data;
  } entry_t;

endpackage

// File: rtl/ex_branch_cmp.sv
// ex_branch_cmp: branch/jump resolution from ALU status.
// Produces taken flag, redirect target and the result to queue.
module ex_branch_cmp
  import exmem_pkg::*;
#(
  parameter int XLEN = EX_XLEN
) (
  input  logic [2:0]      alu_status,
  input  logic [2:0]      br_type,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_out,
  input  logic            is_branch,
  input  logic            is_jump,
  input  logic            jump_reg,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] result
);

  logic            cond;
  logic [XLEN-1:0] rel;
  logic [XLEN-1:0] jtgt;

  assign rel  = pc + imm;
  assign jtgt = jump_reg ? alu_out : rel;

  // Branch condition decoded from funct3 and status bits
  always_comb begin
    cond = 1'b0;
    case (br_type)
      BR_EQ:   cond = alu_status[ST_EQ];
      BR_NE:   cond = ~alu_status[ST_EQ];
      BR_LT:   cond = alu_status[ST_LT];
      BR_GE:   cond = ~alu_status[ST_LT];
      BR_LTU:  cond = alu_status[ST_LTU];
      BR_GEU:  cond = ~alu_status[ST_LTU];
      default: cond = 1'b0;
    endcase
  end

  // Select taken/target/result by instruction class
  always_comb begin
    taken  = 1'b0;
    target = rel;
    result = alu_out;
    unique case (1'b1)
      is_jump: begin
        taken  = 1'b1;
        target = {jtgt[XLEN-1:1], 1'b0};
        result = pc + XLEN'(4);
      end
      is_branch: begin
        taken  = cond;
        target = rel;
      end
      default: begin
        taken = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX->MEM register with branch redirect.
// EX_MEM_SKID_EN adds a skid entry and a registered in_ready.
module ex_mem_reg
  import exmem_pkg::*;
#(
  parameter int XLEN   = EX_XLEN,
  parameter int REG_AW = EX_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   alu_out,
  input  logic [2:0]        alu_status,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   imm,
  input  logic              is_branch,
  input  logic              is_jump,
  input  logic              jump_reg,
  input  logic [2:0]        br_type,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [XLEN-1:0]   store_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [XLEN-1:0]   out_store_data,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] br_result;
  entry_t          in_entry;
  entry_t          main_q;
  logic            main_valid;
  logic            accept;
  logic            drain;

  ex_branch_cmp #(.XLEN(XLEN)) u_cmp (
    .alu_status (alu_status),
    .br_type    (br_type),
    .pc         (pc),
    .imm        (imm),
    .alu_out    (alu_out),
    .is_branch  (is_branch),
    .is_jump    (is_jump),
    .jump_reg   (jump_reg),
    .taken      (br_taken),
    .target     (br_target),
    .result     (br_result)
  );

  assign in_entry = '{
    result:     br_result,
    rd:         rd,
    reg_write:  reg_write,
    mem_read:   mem_read,
    mem_write:  mem_write,
    store_data: store_data
  };

  assign accept = in_valid & in_ready & ~redirect_valid;
  assign drain  = main_valid & out_ready;

  assign out_valid      = main_valid;
  assign out_result     = main_q.result;
  assign out_rd         = main_q.rd;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;
  assign out_store_data = main_q.store_data;

`ifdef EX_MEM_SKID_EN
  entry_t skid_q;
  logic   skid_valid;
  logic   skid_next;
  logic   ready_q;
  logic   skid_move;
  logic   main_load;
  logic   skid_load;

  assign in_ready  = ready_q;
  assign skid_move = drain & skid_valid;
  assign main_load = accept & (~main_valid | (drain & ~skid_valid));
  assign skid_load = accept & ~main_load;
  assign skid_next = skid_load | (skid_valid & ~skid_move);

  // Two-entry queue; skid refills main on the draining edge
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      main_valid <= 1'b0;
      skid_q     <= '0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      if (skid_move)
        main_q <= skid_q;
      else if (main_load)
        main_q <= in_entry;
      if (skid_load)
        skid_q <= in_entry;
      main_valid <= skid_move | main_load
                  | (main_valid & ~drain);
      skid_valid <= skid_next;
      ready_q    <= ~skid_next;
    end
  end
`else
  logic up_q;

  assign in_ready = up_q & (~main_valid | out_ready);

  // Single entry; up_q holds in_ready low through reset
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      main_valid <= 1'b0;
      up_q       <= 1'b0;
    end else begin
      up_q <= 1'b1;
      if (accept)
        main_q <= in_entry;
      main_valid <= accept | (main_valid & ~drain);
    end
  end
`endif

  // One-cycle redirect pulse for every taken accept
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= accept & br_taken;
      if (accept & br_taken)
        redirect_pc <= br_target;
    end
  end

endmodule
